async_fifo_wptr_full: RTL and testbench
=======================================

Name: async_fifo_wptr_full

Overview:
- Write-domain pointer and full-flag generator for the team's asynchronous FIFO.
- Holds the binary write pointer and produces the SRAM write address plus the registered Gray-coded write pointer that the read domain's 2-flop synchronizer samples.
- Consumes the read pointer already synchronized into the write domain, and produces full, almost-full, fill level and a sticky overflow flag.

Parameters:
- ADDR_WIDTH, 3, FIFO address width; depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits wide; legal range is 2 or more.
- AF_MARGIN, 2, walmost_full asserts when the level is at or above depth minus AF_MARGIN; legal range is 1 to depth-1.

Ports:
- clk  in  1  write-domain clock
- arst_n  in  1  reset; synchronous, active-low
- winc  in  1  write request from producer
- wq2_rptr  in  ADDR_WIDTH+1  Gray read pointer, already 2-flop synchronized into clk domain
- woverflow_clr  in  1  clears woverflow
- waddr  out  ADDR_WIDTH  SRAM write address (low bits of binary pointer)
- wen  out  1  SRAM write enable, equal to winc && !wfull (combinational)
- wptr  out  ADDR_WIDTH+1  registered Gray write pointer, goes to the read-domain synchronizer
- wfull  out  1  FIFO full, registered
- walmost_full  out  1  level >= depth-AF_MARGIN, registered
- wlevel  out  ADDR_WIDTH+1  conservative fill count, 0..depth, registered
- woverflow  out  1  sticky: a write was attempted while full

Behaviour:
- Reset (arst_n=0 at a clk edge): wbin, wptr, wlevel, wfull, walmost_full and woverflow all go to 0. Reset takes priority over every other input.
- Accept: push = winc && !wfull. wbin_next = wbin + push, wrapping modulo 2**(ADDR_WIDTH+1).
- Gray pointer: wgray_next = wbin_next ^ (wbin_next >> 1). wptr <= wgray_next. Exactly one bit of wptr changes per accepted write, and it is always driven from a flop.
- waddr = wbin[ADDR_WIDTH-1:0], the current pointer, so data is written at the slot a push targets.
- Full: wfull <= (wgray_next == {~wq2_rptr[AW:AW-1], wq2_rptr[AW-2:0]}), where AW = ADDR_WIDTH.
  - wfull asserts on the same edge that accepts the filling write.
  - wfull deasserts one clk edge after wq2_rptr advances.
- Level: wlevel <= wbin_next - gray2bin(wq2_rptr), computed at ADDR_WIDTH+1 bits with natural wrap. The result always lies in 0..depth. It is pessimistic, because wq2_rptr lags the real read pointer.
- walmost_full <= (level_next >= depth - AF_MARGIN).
- Overflow: a cycle with winc && wfull sets woverflow. woverflow_clr clears it. If both happen in the same cycle, set wins. A rejected write leaves wbin and wptr unchanged and wen=0.
- Wrap-around: after 2**(ADDR_WIDTH+1) pushes the pointer returns to 0 and the MSB toggles every depth pushes. Full detection stays correct across the wrap.
- Simultaneous push and read-pointer advance: both are folded into the same next-state computation, so wfull stays at 0 when the two cancel.
- Reset mid-operation: the pointer returns to 0 irrespective of wq2_rptr. The read side must be reset in the same window. That is a system-level requirement and is not checked here.

Decomposition:
- Package async_fifo_pkg holds:
  - functions bin2gray and gray2bin, parameterized by width through a localparam-sized typedef;
  - localparam DEPTH_OF(ADDR_WIDTH) helper.
- The read-side counterpart shares this package.
- One sub-module, gray_ptr_counter:
  - inputs clk, arst_n, inc, en;
  - outputs bin, bin_next, gray;
  - reused later by the read-pointer/empty block.
- Full, level and overflow logic stay in this module.

Test Plan (ADDR_WIDTH=3, AF_MARGIN=2, depth 8):
- Reset: hold arst_n=0 for 2 cycles with winc=1 → wptr=0, waddr=0, wfull=0, wlevel=0, woverflow=0.
- Fill: wq2_rptr=0, winc=1 for 8 cycles → waddr steps 0..7; wptr steps 0,1,3,2,6,7,5,4, ending at gray(8)=4'b1100. walmost_full rises after the 6th write; wfull rises on the 8th write's edge; wlevel=8.
- Overflow: continue winc=1 while full → wen=0, wptr holds 4'b1100, woverflow=1. Pulse woverflow_clr with winc=0 → woverflow=0. Same-cycle clr with a blocked write → woverflow stays 1.
- Drain release: while full, set wq2_rptr=gray(1)=4'b0001 → wfull=0 one edge later, wlevel=7. Push once → wfull=1 again, with wptr=gray(9)=4'b1101.
- Wrap: run 20 push/pop-tracking cycles (wq2_rptr = wptr delayed 2 cycles) → wbin wraps 15→0 with no false full, and wptr never changes more than one bit per cycle (assertion).
- Simultaneous: from level 7, apply winc=1 and an advance of wq2_rptr in the same cycle → wlevel stays 7, wfull=0.

Source files
------------

// File: rtl/async_fifo_pkg.sv
// Shared helpers for the asynchronous FIFO pointer blocks (write and read side).
// Gray/binary conversion works on a wide fixed-size pointer type; callers
// zero-extend narrower pointers into it and take back the low bits.
package async_fifo_pkg;

    localparam int unsigned PtrMaxW = 32;

    typedef logic [PtrMaxW-1:0] ptr_t;

    // Number of FIFO slots for a given address width.
    function automatic int unsigned depth_of(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    // Zero-extension is harmless: leading zeros do not change the lower bits.
    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b = '0;
        b[PtrMaxW-1] = g[PtrMaxW-1];
        for (int i = PtrMaxW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/async_fifo_wptr_full_gray_ptr_counter.sv
// Binary pointer with a registered Gray copy for clock-domain crossing.
// Shared by the write-pointer/full and read-pointer/empty blocks.
module gray_ptr_counter
    import async_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             inc,
    input  logic             en,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] bin_next,
    output logic [WIDTH-1:0] gray
);

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] gray_d;
    ptr_t             gray_wide;

    // Next binary pointer and its Gray encoding; wraps modulo 2**WIDTH.
    always_comb begin
        bin_next  = bin_q + {{(WIDTH-1){1'b0}}, inc & en};
        gray_wide = bin2gray(ptr_t'(bin_next));
        gray_d    = gray_wide[WIDTH-1:0];
    end

    // Pointer state; Gray output comes straight from a flop so it is glitch-free.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            bin_q  <= '0;
            gray_q <= '0;
        end else begin
            bin_q  <= bin_next;
            gray_q <= gray_d;
        end
    end

    assign bin  = bin_q;
    assign gray = gray_q;

endmodule

// File: rtl/async_fifo_wptr_full.sv
// Write-domain pointer, full/almost-full, fill level and sticky overflow
// generation for the asynchronous FIFO.
module async_fifo_wptr_full
    import async_fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned AF_MARGIN  = 2
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  winc,
    input  logic [ADDR_WIDTH:0]   wq2_rptr,
    input  logic                  woverflow_clr,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic                  wen,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic                  wfull,
    output logic                  walmost_full,
    output logic [ADDR_WIDTH:0]   wlevel,
    output logic                  woverflow
);

    localparam int unsigned AW    = ADDR_WIDTH;
    localparam int unsigned PW    = ADDR_WIDTH + 1;
    localparam int unsigned Depth = depth_of(ADDR_WIDTH);
    localparam logic [PW-1:0] AfThresh = PW'(Depth - AF_MARGIN);

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] rbin_sync;
    logic [PW-1:0] full_cmp;
    ptr_t          wgray_wide;
    ptr_t          rbin_wide;

    logic          wfull_q, wfull_d;
    logic          walmost_full_q, walmost_full_d;
    logic [PW-1:0] wlevel_q, wlevel_d;
    logic          woverflow_q, woverflow_d;

    gray_ptr_counter #(
        .WIDTH (PW)
    ) u_wptr (
        .clk      (clk),
        .arst_n   (arst_n),
        .inc      (winc),
        .en       (!wfull_q),
        .bin      (wbin),
        .bin_next (wbin_next),
        .gray     (wptr)
    );

    // Flag and level next-state; pending push and read-pointer advance are
    // folded together so they cancel cleanly.
    always_comb begin
        wgray_wide = bin2gray(ptr_t'(wbin_next));
        wgray_next = wgray_wide[PW-1:0];
        rbin_wide  = gray2bin(ptr_t'(wq2_rptr));
        rbin_sync  = rbin_wide[PW-1:0];
        // Full when write pointer is one lap ahead: top two Gray bits inverted.
        full_cmp   = {~wq2_rptr[AW:AW-1], wq2_rptr[AW-2:0]};

        wfull_d        = (wgray_next == full_cmp);
        wlevel_d       = wbin_next - rbin_sync;
        walmost_full_d = (wlevel_d >= AfThresh);

        // Set has priority over clear.
        woverflow_d = woverflow_q;
        if (woverflow_clr) begin
            woverflow_d = 1'b0;
        end
        if (winc && wfull_q) begin
            woverflow_d = 1'b1;
        end
    end

    // Registered status flags and level.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            wfull_q        <= 1'b0;
            walmost_full_q <= 1'b0;
            wlevel_q       <= '0;
            woverflow_q    <= 1'b0;
        end else begin
            wfull_q        <= wfull_d;
            walmost_full_q <= walmost_full_d;
            wlevel_q       <= wlevel_d;
            woverflow_q    <= woverflow_d;
        end
    end

    assign waddr        = wbin[AW-1:0];
    assign wen          = winc && !wfull_q;
    assign wfull        = wfull_q;
    assign walmost_full = walmost_full_q;
    assign wlevel       = wlevel_q;
    assign woverflow    = woverflow_q;

endmodule

// File: tb/tb_async_fifo_wptr_full.sv
// Scoreboard bench for async_fifo_wptr_full (ADDR_WIDTH=3, AF_MARGIN=2).
module tb_async_fifo_wptr_full;

    logic       clk;
    logic       arst_n;
    logic       winc;
    logic [3:0] wq2_rptr;
    logic       woverflow_clr;
    logic [2:0] waddr;
    logic       wen;
    logic [3:0] wptr;
    logic       wfull;
    logic       walmost_full;
    logic [3:0] wlevel;
    logic       woverflow;

    async_fifo_wptr_full #(
        .ADDR_WIDTH (3),
        .AF_MARGIN  (2)
    ) dut (
        .clk           (clk),
        .arst_n        (arst_n),
        .winc          (winc),
        .wq2_rptr      (wq2_rptr),
        .woverflow_clr (woverflow_clr),
        .waddr         (waddr),
        .wen           (wen),
        .wptr          (wptr),
        .wfull         (wfull),
        .walmost_full  (walmost_full),
        .wlevel        (wlevel),
        .woverflow     (woverflow)
    );

    typedef struct {
        string      name;
        bit         chk_wen;
        logic       wen;
        logic [2:0] waddr;
        logic [3:0] wptr;
        logic       full;
        logic       af;
        logic [3:0] level;
        logic       ovf;
    } exp_t;

    exp_t       sb_q[$];
    int         checks = 0;
    int         errors = 0;
    bit         onehot_en = 0;
    logic [3:0] gray_tab [16];
    logic [3:0] wptr_prev;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus and queue the expected response.
    task automatic step(input string name, input logic rst_n, input logic inc,
                        input logic [3:0] rptr, input logic clr,
                        input bit chk_wen, input logic e_wen, input logic [2:0] e_addr,
                        input logic [3:0] e_ptr, input logic e_full, input logic e_af,
                        input logic [3:0] e_level, input logic e_ovf);
        exp_t e;
        @(negedge clk);
        arst_n        = rst_n;
        winc          = inc;
        wq2_rptr      = rptr;
        woverflow_clr = clr;
        e.name    = name;
        e.chk_wen = chk_wen;
        e.wen     = e_wen;
        e.waddr   = e_addr;
        e.wptr    = e_ptr;
        e.full    = e_full;
        e.af      = e_af;
        e.level   = e_level;
        e.ovf     = e_ovf;
        sb_q.push_back(e);
    endtask

    // Monitor: wen checked mid-cycle, registered outputs just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() != 0) begin
                e = sb_q[0];
                if (e.chk_wen) cmp({e.name, ".wen"}, 32'(wen), 32'(e.wen));
                @(posedge clk);
                #1;
                e = sb_q.pop_front();
                cmp({e.name, ".waddr"}, 32'(waddr), 32'(e.waddr));
                cmp({e.name, ".wptr"}, 32'(wptr), 32'(e.wptr));
                cmp({e.name, ".wfull"}, 32'(wfull), 32'(e.full));
                cmp({e.name, ".walmost_full"}, 32'(walmost_full), 32'(e.af));
                cmp({e.name, ".wlevel"}, 32'(wlevel), 32'(e.level));
                cmp({e.name, ".woverflow"}, 32'(woverflow), 32'(e.ovf));
            end
        end
    end

    // Gray pointer may change at most one bit per clock while enabled.
    initial begin
        wptr_prev = '0;
        forever begin
            @(posedge clk);
            #1;
            if (onehot_en) cmp("wptr_onebit_step", 32'($countones(wptr ^ wptr_prev) <= 1), 32'd1);
            wptr_prev = wptr;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] rp;
        gray_tab = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                     4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
        arst_n = 1'b0; winc = 1'b0; wq2_rptr = '0; woverflow_clr = 1'b0;

        // Reset with a write request pending: reset wins.
        repeat (2) step("reset", 0, 1, 4'h0, 0, 0, 0, 3'd0, 4'h0, 0, 0, 4'd0, 0);

        // Fill 8 slots against a stationary read pointer.
        for (int k = 0; k < 8; k++) begin
            step($sformatf("fill%0d", k), 1, 1, 4'h0, 0, 1, 1, 3'(k + 1),
                 gray_tab[(k + 1) % 16], k == 7, (k + 1) >= 6, 4'(k + 1), 0);
        end

        // Overflow set, clear, then set-beats-clear.
        step("ovf_set",    1, 1, 4'h0, 0, 1, 0, 3'd0, 4'hC, 1, 1, 4'd8, 1);
        step("ovf_clr",    1, 0, 4'h0, 1, 1, 0, 3'd0, 4'hC, 1, 1, 4'd8, 0);
        step("ovf_reset",  1, 1, 4'h0, 0, 1, 0, 3'd0, 4'hC, 1, 1, 4'd8, 1);
        step("ovf_setwin", 1, 1, 4'h0, 1, 1, 0, 3'd0, 4'hC, 1, 1, 4'd8, 1);

        // Drain release and refill past the lap boundary.
        step("drain",   1, 0, 4'h1, 0, 1, 0, 3'd0, 4'hC, 0, 1, 4'd7, 1);
        step("refill",  1, 1, 4'h1, 0, 1, 1, 3'd1, 4'hD, 1, 1, 4'd8, 1);
        step("drain2",  1, 0, 4'h3, 0, 1, 0, 3'd1, 4'hD, 0, 1, 4'd7, 1);
        // Push and read advance in the same cycle cancel out.
        step("simul",   1, 1, 4'h2, 0, 1, 1, 3'd2, 4'hF, 0, 1, 4'd7, 1);

        // Reset mid-operation ignores the read pointer.
        repeat (2) step("reset2", 0, 1, 4'h2, 0, 0, 0, 3'd0, 4'h0, 0, 0, 4'd0, 0);

        // Wrap: read pointer trails the write pointer by two cycles.
        onehot_en = 1;
        for (int i = 0; i < 20; i++) begin
            rp = (i >= 2) ? gray_tab[(i - 2) % 16] : 4'h0;
            step($sformatf("wrap%0d", i), 1, 1, rp, 0, 1, 1, 3'(i + 1),
                 gray_tab[(i + 1) % 16], 0, 0, (i + 1 < 3) ? 4'(i + 1) : 4'd3, 0);
        end

        for (int n = 0; n < 10 && sb_q.size() != 0; n++) @(posedge clk);
        repeat (2) @(negedge clk);
        onehot_en = 0;
        cmp("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
